// File: rtl/sgm_pkg.sv
// rtl/sgm_pkg.sv - shared cost/disparity parameters, FSM encoding and clog2 helper
package sgm_pkg;

    localparam int DISPARITY_LEVELS = 64;
    localparam int ACC_COST_BITS    = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/disparity_selector_if.sv
// rtl/disparity_selector_if.sv - cost-array input and disparity result handshake bundle
interface disparity_selector_if #(
    parameter int DISPARITY_LEVELS = sgm_pkg::DISPARITY_LEVELS,
    parameter int ACC_COST_BITS    = sgm_pkg::ACC_COST_BITS
);
    import sgm_pkg::*;

    localparam int DISP_W = clog2(DISPARITY_LEVELS);

    logic                                      in_l_valid;
    logic                                      out_l_ready;
    logic [ACC_COST_BITS*DISPARITY_LEVELS-1:0] in_L_arr;
    logic                                      out_disp_valid;
    logic                                      in_disp_ready;
    logic [DISP_W-1:0]                         out_disparity;
    logic [ACC_COST_BITS-1:0]                  out_min_cost;
    logic                                      out_ambiguous;

    modport slave (
        input  in_l_valid, in_L_arr, in_disp_ready,
        output out_l_ready, out_disp_valid, out_disparity, out_min_cost, out_ambiguous
    );

    modport master (
        output in_l_valid, in_L_arr, in_disp_ready,
        input  out_l_ready, out_disp_valid, out_disparity, out_min_cost, out_ambiguous
    );

endinterface

// File: rtl/disparity_selector_lane_min_reduce.sv
// rtl/disparity_selector_lane_min_reduce.sv - combinational min tree over LANES cost words (second-min under UNIQUENESS_CHECK_EN)
module lane_min_reduce #(
    parameter int  LANES = 8,
    parameter int  W     = 8,
    localparam int OFF_W = (LANES > 1) ? sgm_pkg::clog2(LANES) : 1
) (
    input  logic [LANES*W-1:0] in_words,
    output logic [W-1:0]       out_min,
    output logic [OFF_W-1:0]   out_off
`ifdef UNIQUENESS_CHECK_EN
    ,
    output logic [W-1:0]       out_sec
`endif
);
    import sgm_pkg::*;

    // Heap layout: leaves at LANES..2*LANES-1, node i merges 2i (lower offsets) and 2i+1.
    logic [W-1:0]     node_min [1:2*LANES-1];
    logic [OFF_W-1:0] node_off [1:2*LANES-1];
`ifdef UNIQUENESS_CHECK_EN
    logic [W-1:0]     node_sec [1:2*LANES-1];
`endif

    always_comb begin
        for (int i = 1; i < 2*LANES; i++) begin
            node_min[i] = '0;
            node_off[i] = '0;
`ifdef UNIQUENESS_CHECK_EN
            node_sec[i] = '1;
`endif
        end
        for (int i = 0; i < LANES; i++) begin
            node_min[LANES+i] = in_words[i*W +: W];
            node_off[LANES+i] = OFF_W'(i);
        end
        // Right child wins only when strictly smaller, so ties keep the lower disparity.
        for (int i = LANES - 1; i >= 1; i--) begin
            if (node_min[2*i+1] < node_min[2*i]) begin
                node_min[i] = node_min[2*i+1];
                node_off[i] = node_off[2*i+1];
`ifdef UNIQUENESS_CHECK_EN
                node_sec[i] = (node_min[2*i] < node_sec[2*i+1]) ? node_min[2*i] : node_sec[2*i+1];
`endif
            end else begin
                node_min[i] = node_min[2*i];
                node_off[i] = node_off[2*i];
`ifdef UNIQUENESS_CHECK_EN
                node_sec[i] = (node_min[2*i+1] < node_sec[2*i]) ? node_min[2*i+1] : node_sec[2*i];
`endif
            end
        end
        out_min = node_min[1];
        out_off = node_off[1];
`ifdef UNIQUENESS_CHECK_EN
        out_sec = node_sec[1];
`endif
    end

endmodule

// File: rtl/disparity_selector.sv
// rtl/disparity_selector.sv - winner-take-all disparity scan, LANES costs per cycle; UNIQUENESS_CHECK_EN adds the ambiguity flag
module disparity_selector #(
    parameter int DISPARITY_LEVELS = sgm_pkg::DISPARITY_LEVELS,
    parameter int ACC_COST_BITS    = sgm_pkg::ACC_COST_BITS,
    parameter int LANES            = 8,
    parameter int UNIQ_RATIO_Q4    = 2
) (
    input logic                 in_clk,
    input logic                 in_rst_n,
    disparity_selector_if.slave bus
);
    import sgm_pkg::*;

    localparam int DISP_W  = clog2(DISPARITY_LEVELS);
    localparam int OFF_W   = (LANES > 1) ? clog2(LANES) : 1;
    localparam int ARR_W   = ACC_COST_BITS * DISPARITY_LEVELS;
    localparam int SLICE_W = ACC_COST_BITS * LANES;
    localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(DISPARITY_LEVELS - LANES);

    if (LANES < 1 || (LANES & (LANES - 1)) != 0 || (DISPARITY_LEVELS % LANES) != 0 || UNIQ_RATIO_Q4 < 0) begin : g_bad_cfg
        $error("disparity_selector: LANES must be a power of two dividing DISPARITY_LEVELS");
    end

    state_t                   state_q, state_d;
    logic [ARR_W-1:0]         arr_q, arr_d;
    logic [DISP_W-1:0]        idx_q, idx_d;
    logic [ACC_COST_BITS-1:0] best_q, best_d;
    logic [DISP_W-1:0]        best_idx_q, best_idx_d;
    logic                     valid_q, valid_d;
    logic [DISP_W-1:0]        disparity_q, disparity_d;
    logic [ACC_COST_BITS-1:0] min_cost_q, min_cost_d;
    logic                     ambiguous_q, ambiguous_d;

    logic [SLICE_W-1:0]       lane_words;
    logic [ACC_COST_BITS-1:0] lane_min;
    logic [OFF_W-1:0]         lane_off;
    logic [ACC_COST_BITS-1:0] merge_best;
    logic [DISP_W-1:0]        merge_idx;
    logic                     merge_ambig;
    logic                     l_ready;
    logic                     accept;

    assign lane_words = arr_q[int'(idx_q)*ACC_COST_BITS +: SLICE_W];

`ifdef UNIQUENESS_CHECK_EN
    localparam int WIDE_W = ACC_COST_BITS + 5;

    logic [ACC_COST_BITS-1:0] sec_q, sec_d;
    logic [ACC_COST_BITS-1:0] lane_sec;
    logic [ACC_COST_BITS-1:0] merge_sec;
    logic [WIDE_W-1:0]        sec_scaled;
    logic [WIDE_W-1:0]        best_scaled;

    lane_min_reduce #(.LANES(LANES), .W(ACC_COST_BITS)) u_reduce (
        .in_words (lane_words),
        .out_min  (lane_min),
        .out_off  (lane_off),
        .out_sec  (lane_sec)
    );

    assign sec_scaled  = WIDE_W'(merge_sec) << 4;
    assign best_scaled = WIDE_W'(merge_best) * WIDE_W'(16 + UNIQ_RATIO_Q4);
    assign merge_ambig = (sec_scaled <= best_scaled);
`else
    lane_min_reduce #(.LANES(LANES), .W(ACC_COST_BITS)) u_reduce (
        .in_words (lane_words),
        .out_min  (lane_min),
        .out_off  (lane_off)
    );

    assign merge_ambig = 1'b0;
`endif

    // Strict < keeps the earlier winner on ties; a displaced best or tied lane min becomes second.
    always_comb begin
        merge_best = best_q;
        merge_idx  = best_idx_q;
`ifdef UNIQUENESS_CHECK_EN
        merge_sec  = (lane_min < sec_q) ? lane_min : sec_q;
`endif
        if (lane_min < best_q) begin
            merge_best = lane_min;
            merge_idx  = idx_q + DISP_W'(lane_off);
`ifdef UNIQUENESS_CHECK_EN
            merge_sec  = (best_q < lane_sec) ? best_q : lane_sec;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        arr_d       = arr_q;
        idx_d       = idx_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        valid_d     = valid_q;
        disparity_d = disparity_q;
        min_cost_d  = min_cost_q;
        ambiguous_d = ambiguous_q;
`ifdef UNIQUENESS_CHECK_EN
        sec_d       = sec_q;
`endif
        l_ready = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                l_ready = 1'b1;
                accept  = bus.in_l_valid;
            end
            ST_SCAN: begin
                best_d     = merge_best;
                best_idx_d = merge_idx;
`ifdef UNIQUENESS_CHECK_EN
                sec_d      = merge_sec;
`endif
                idx_d      = idx_q + DISP_W'(LANES);
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_DONE;
                    valid_d     = 1'b1;
                    disparity_d = merge_idx;
                    min_cost_d  = merge_best;
                    ambiguous_d = merge_ambig;
                end
            end
            ST_DONE: begin
                l_ready = bus.in_disp_ready;
                if (bus.in_disp_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    accept  = bus.in_l_valid;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            arr_d      = bus.in_L_arr;
            idx_d      = '0;
            best_d     = '1;
            best_idx_d = '0;
`ifdef UNIQUENESS_CHECK_EN
            sec_d      = '1;
`endif
            state_d    = ST_SCAN;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ST_IDLE;
            arr_q       <= '0;
            idx_q       <= '0;
            best_q      <= '1;
            best_idx_q  <= '0;
            valid_q     <= 1'b0;
            disparity_q <= '0;
            min_cost_q  <= '0;
            ambiguous_q <= 1'b0;
`ifdef UNIQUENESS_CHECK_EN
            sec_q       <= '1;
`endif
        end else begin
            state_q     <= state_d;
            arr_q       <= arr_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            valid_q     <= valid_d;
            disparity_q <= disparity_d;
            min_cost_q  <= min_cost_d;
            ambiguous_q <= ambiguous_d;
`ifdef UNIQUENESS_CHECK_EN
            sec_q       <= sec_d;
`endif
        end
    end

    assign bus.out_l_ready    = l_ready;
    assign bus.out_disp_valid = valid_q;
    assign bus.out_disparity  = disparity_q;
    assign bus.out_min_cost   = min_cost_q;
    assign bus.out_ambiguous  = ambiguous_q;

endmodule

// File: tb/tb_disparity_selector.sv
// tb/tb_disparity_selector.sv - directed and streaming scoreboard bench for disparity_selector
module tb_disparity_selector;

    localparam int DL    = 64;
    localparam int AB    = 8;
    localparam int LN    = 8;
    localparam int NSCAN = DL / LN;
    localparam int AW    = DL * AB;

    typedef struct packed {
        logic [5:0] disp;
        logic [7:0] cost;
        logic       amb;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    res_t sb[$];

    disparity_selector_if #(.DISPARITY_LEVELS(DL), .ACC_COST_BITS(AB)) bus ();

    disparity_selector #(
        .DISPARITY_LEVELS (DL),
        .ACC_COST_BITS    (AB),
        .LANES            (LN),
        .UNIQ_RATIO_Q4    (2)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [AW-1:0] arr);
        res_t r;
        int bd, bc, sc;
        bd = 0;
        bc = int'(arr[7:0]);
        for (int d = 1; d < DL; d++)
            if (int'(arr[d*AB +: AB]) < bc) begin
                bc = int'(arr[d*AB +: AB]);
                bd = d;
            end
        sc = 255;
        for (int d = 0; d < DL; d++)
            if (d != bd && int'(arr[d*AB +: AB]) < sc) sc = int'(arr[d*AB +: AB]);
        r.disp = 6'(bd);
        r.cost = 8'(bc);
`ifdef UNIQUENESS_CHECK_EN
        r.amb = (sc * 16 <= bc * 18);
`else
        r.amb = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [AW-1:0] fill(input int v);
        logic [AW-1:0] a;
        for (int d = 0; d < DL; d++) a[d*AB +: AB] = 8'(v);
        return a;
    endfunction

    function automatic logic [AW-1:0] rand_arr();
        logic [AW-1:0] a;
        for (int d = 0; d < DL; d++) a[d*AB +: AB] = 8'($urandom_range(0, 63));
        return a;
    endfunction

    // Scoreboard: push at an accepting edge, pop and compare at a consuming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_disp_valid && bus.in_disp_ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("sb_result", 32'(bus.out_disparity) << 9 | 32'(bus.out_min_cost) << 1 | 32'(bus.out_ambiguous), 32'(sb.pop_front()));
            end
            if (bus.in_l_valid && bus.out_l_ready) sb.push_back(model(bus.in_L_arr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] arr);
        int n;
        n = 0;
        bus.in_L_arr   = arr;
        bus.in_l_valid = 1'b1;
        while (bus.out_l_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("send_ready", 32'(bus.out_l_ready), 32'd1);
        step();
        bus.in_l_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_disp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic consume();
        bus.in_disp_ready = 1'b1;
        step();
        bus.in_disp_ready = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        res_t          e;
        int            n, wcnt, cyc_now, last_acc;

        bus.in_l_valid    = 1'b0;
        bus.in_disp_ready = 1'b0;
        bus.in_L_arr      = '0;
        repeat (3) step();
        chk("rst_valid", 32'(bus.out_disp_valid), 32'd0);
        chk("rst_disp", 32'(bus.out_disparity), 32'd0);
        chk("rst_cost", 32'(bus.out_min_cost), 32'd0);
        chk("rst_amb", 32'(bus.out_ambiguous), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_l_ready", 32'(bus.out_l_ready), 32'd1);

        a = fill(200);
        a[37*AB +: AB] = 8'd5;
        send(a);
        wait_valid(n);
        chk("latency_single", 32'(n), 32'(NSCAN));
        chk("single_disp", 32'(bus.out_disparity), 32'd37);
        chk("single_cost", 32'(bus.out_min_cost), 32'd5);
        consume();
        chk("idle_after_consume", 32'(bus.out_l_ready), 32'd1);

        send(rand_arr());
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midscan_rst_valid", 32'(bus.out_disp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("midscan_rst_l_ready", 32'(bus.out_l_ready), 32'd1);
        chk("midscan_rst_valid_after", 32'(bus.out_disp_valid), 32'd0);

        a = fill(100);
        a[12*AB +: AB] = 8'd3;
        a[50*AB +: AB] = 8'd3;
        send(a);
        wait_valid(n);
        chk("latency_tie", 32'(n), 32'(NSCAN));
        chk("tie_disp", 32'(bus.out_disparity), 32'd12);
        chk("tie_cost", 32'(bus.out_min_cost), 32'd3);
        consume();

        send(fill(255));
        wait_valid(n);
        chk("all_ones_disp", 32'(bus.out_disparity), 32'd0);
        chk("all_ones_cost", 32'(bus.out_min_cost), 32'd255);
        consume();

        a = rand_arr();
        e = model(a);
        send(a);
        wait_valid(n);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(bus.out_disp_valid), 32'd1);
            chk("bp_l_ready", 32'(bus.out_l_ready), 32'd0);
            chk("bp_disp", 32'(bus.out_disparity), 32'(e.disp));
            chk("bp_cost", 32'(bus.out_min_cost), 32'(e.cost));
            step();
        end
        bus.in_L_arr      = rand_arr();
        bus.in_l_valid    = 1'b1;
        bus.in_disp_ready = 1'b1;
        #1;
        chk("bp_release_l_ready", 32'(bus.out_l_ready), 32'd1);
        step();
        bus.in_l_valid    = 1'b0;
        bus.in_disp_ready = 1'b0;
        wait_valid(n);
        chk("latency_same_cycle", 32'(n), 32'(NSCAN));
        consume();

        a = fill(200);
        a[10*AB +: AB] = 8'd40;
        a[30*AB +: AB] = 8'd42;
        send(a);
        wait_valid(n);
        chk("amb_close_disp", 32'(bus.out_disparity), 32'd10);
`ifdef UNIQUENESS_CHECK_EN
        chk("amb_close", 32'(bus.out_ambiguous), 32'd1);
`else
        chk("amb_close", 32'(bus.out_ambiguous), 32'd0);
`endif
        consume();
        a[30*AB +: AB] = 8'd60;
        send(a);
        wait_valid(n);
        chk("amb_far", 32'(bus.out_ambiguous), 32'd0);
        consume();

        bus.in_disp_ready = 1'b1;
        bus.in_l_valid    = 1'b1;
        bus.in_L_arr      = rand_arr();
        last_acc = 0;
        for (int p = 0; p < 100; p++) begin
            wcnt = 0;
            while (bus.out_l_ready !== 1'b1 && wcnt < 30) begin
                step();
                wcnt++;
            end
            step();
            cyc_now = cycle;
            if (p > 0) chk("stream_period", 32'(cyc_now - last_acc), 32'(NSCAN + 1));
            last_acc = cyc_now;
            bus.in_L_arr = rand_arr();
        end
        bus.in_l_valid = 1'b0;
        wcnt = 0;
        while (sb.size() > 0 && wcnt < 40) begin
            step();
            wcnt++;
        end
        chk("stream_drained", 32'(sb.size()), 32'd0);
        bus.in_disp_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
